// File: rtl/uart_pkg.sv
// Shared UART register-port definitions: register map constants and the
// arbiter access-sequencing states.
package uart_pkg;

  localparam logic [5:0] UART_REG_CTRL = 6'h00;
  localparam logic [1:0] UART_RGN_RX   = 2'b01;
  localparam logic [1:0] UART_RGN_TX   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_lock_timer.sv
// Idle timer for the transmit lock: counts cycles the owner is not being served
// and forces a release, with a one-cycle error pulse, once the limit is reached.
module uart_lock_timer
  import uart_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_valid_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expire_o,
  output logic lock_err_o
);

  localparam int CntW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(LOCK_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_err_q;

  assign expire_o   = lock_valid_i && (cnt_q == Limit);
  assign lock_err_o = lock_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o || !lock_valid_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_err_q <= expire_o;
    end
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Round-robin arbiter between two masters on the UART register port, with a
// transmit lock so one master's TX buffer fill cannot interleave with the other's.
module uart_port_arbiter
  import uart_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [5:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [5:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [5:0]  uart_addr,
  output logic [31:0] uart_wdata,
  output logic        uart_we,
  input  logic [31:0] uart_rdata,
  output logic        lock_err
);

  arb_state_e  state_q;
  logic        grant_q, last_grant_q;
  logic        lock_valid_q, lock_owner_q;
  logic        m0_ack_q, m1_ack_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic [5:0]  uart_addr_q;
  logic [31:0] uart_wdata_q;
  logic        uart_we_q;

  logic expire, lock_held, elig0, elig1, pick, serving_owner, wr_tx, wr_commit;

  // An expiring lock no longer blocks anyone, even on the edge it expires.
  assign lock_held = lock_valid_q && !expire;
  assign elig0     = m0_req && (!lock_held || (lock_owner_q == 1'b0));
  assign elig1     = m1_req && (!lock_held || (lock_owner_q == 1'b1));
  assign pick      = (elig0 && elig1) ? ~last_grant_q : elig1;

  assign serving_owner = (state_q != ST_IDLE) && (grant_q == lock_owner_q);
  assign wr_tx     = (state_q == ST_ISSUE) && uart_we_q && (uart_addr_q[5:4] == UART_RGN_TX);
  assign wr_commit = (state_q == ST_ISSUE) && uart_we_q && (uart_addr_q == UART_REG_CTRL)
                     && lock_valid_q && (lock_owner_q == grant_q);

  uart_lock_timer #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .lock_valid_i (lock_valid_q),
    .run_i        (lock_valid_q && !serving_owner),
    .clr_i        (wr_tx),
    .expire_o     (expire),
    .lock_err_o   (lock_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      uart_addr_q  <= '0;
      uart_wdata_q <= '0;
      uart_we_q    <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      if (expire) lock_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (elig0 || elig1) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            uart_addr_q  <= pick ? m1_addr  : m0_addr;
            uart_wdata_q <= pick ? m1_wdata : m0_wdata;
            uart_we_q    <= pick ? m1_we    : m0_we;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          uart_we_q <= 1'b0;
          if (grant_q) begin
            m1_rdata_q <= uart_rdata;
            m1_ack_q   <= 1'b1;
          end else begin
            m0_rdata_q <= uart_rdata;
            m0_ack_q   <= 1'b1;
          end
          // The access that just completed may take or commit the TX lock.
          if (wr_tx) begin
            lock_valid_q <= 1'b1;
            lock_owner_q <= grant_q;
          end else if (wr_commit) begin
            lock_valid_q <= 1'b0;
          end
          state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign uart_addr  = uart_addr_q;
  assign uart_wdata = uart_wdata_q;
  assign uart_we    = uart_we_q;

endmodule
